bus_cmd_sequencer: RTL and testbench

- Command front-end that sits directly upstream of master_reg. It buffers bus commands (read/write, address, write data) from a producer in a small FIFO.
- An FSM issues one command at a time on the master-side request/grant/acknowledge signals.
- Each command returns exactly one response (read data or error) to the producer. A timeout guards against a hung arbiter or slave.

---
 rtl/bus_cmd_sequencer.sv | 140 ++++++++++++++
 tb/tb_bus_cmd_sequencer.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/bus_cmd_sequencer.sv
// Buffers bus commands in a FIFO and issues them one at a time on req/gnt/ack, returning one response each.
// First m_req two cycles after a push into an empty idle queue; cmd_ready follows the registered count, responses hold until rsp_ready.
module bus_cmd_sequencer #(
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 8,
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       cmd_valid,
  output logic                       cmd_ready,
  input  logic                       cmd_write,
  input  logic [ADDR_W-1:0]          cmd_addr,
  input  logic [DATA_W-1:0]          cmd_wdata,
  output logic                       m_req,
  output logic                       m_write,
  output logic [ADDR_W-1:0]          m_addr,
  output logic [DATA_W-1:0]          m_wdata,
  input  logic                       m_gnt,
  input  logic                       m_ack,
  input  logic [DATA_W-1:0]          m_rdata,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic [DATA_W-1:0]          rsp_rdata,
  output logic                       rsp_err,
  output logic [$clog2(DEPTH):0]     fifo_count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, REQ, WAIT_ACK, RESP} state_t;

  typedef struct packed {
    logic              write;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } cmd_t;

  cmd_t          mem [DEPTH];
  cmd_t          head;
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic [TW-1:0] timer;
  state_t        state;
  logic          push;
  logic          pop;

  assign cmd_ready  = (count != CW'(DEPTH));
  assign fifo_count = count;
  assign push       = cmd_valid && cmd_ready;
  assign pop        = (state == IDLE) && (count != '0);
  assign head       = mem[rd_ptr];

  // Storage carries no reset; validity is tracked by count alone.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= {cmd_write, cmd_addr, cmd_wdata};
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      if (push && !pop) begin
        count <= count + CW'(1);
      end else if (pop && !push) begin
        count <= count - CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      timer     <= '0;
      m_req     <= 1'b0;
      m_write   <= 1'b0;
      m_addr    <= '0;
      m_wdata   <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (pop) begin
            m_write <= head.write;
            m_addr  <= head.addr;
            m_wdata <= head.wdata;
            m_req   <= 1'b1;
            timer   <= '0;
            state   <= REQ;
          end
        end
        REQ, WAIT_ACK: begin
          // An ack on the last allowed cycle still counts as a normal completion.
          if (m_ack) begin
            m_req     <= 1'b0;
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b0;
            rsp_rdata <= m_write ? '0 : m_rdata;
            state     <= RESP;
          end else if (timer == TW'(TIMEOUT - 1)) begin
            m_req     <= 1'b0;
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b1;
            rsp_rdata <= '0;
            state     <= RESP;
          end else begin
            timer <= timer + TW'(1);
            if (state == REQ && m_gnt) begin
              state <= WAIT_ACK;
            end
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bus_cmd_sequencer.sv
// Directed bench for bus_cmd_sequencer with a response scoreboard queue.
module tb_bus_cmd_sequencer;

  logic       clk;
  logic       reset;
  logic       cmd_valid;
  logic       cmd_ready;
  logic       cmd_write;
  logic [7:0] cmd_addr;
  logic [7:0] cmd_wdata;
  logic       m_req;
  logic       m_write;
  logic [7:0] m_addr;
  logic [7:0] m_wdata;
  logic       m_gnt;
  logic       m_ack;
  logic [7:0] m_rdata;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [7:0] rsp_rdata;
  logic       rsp_err;
  logic [2:0] fifo_count;

  int checks = 0;
  int errors = 0;
  logic [8:0] exp_q[$];

  bus_cmd_sequencer #(.ADDR_W(8), .DATA_W(8), .DEPTH(4), .TIMEOUT(16)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .m_req(m_req), .m_write(m_write), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_gnt(m_gnt), .m_ack(m_ack), .m_rdata(m_rdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .fifo_count(fifo_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  // Expected response {err, rdata} is queued as the command is pushed.
  task automatic push_cmd(input string tag, input logic w, input logic [7:0] a,
                          input logic [7:0] d, input logic exp_err, input logic [7:0] exp_rdata);
    int n = 0;
    cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_wdata = d;
    while (!cmd_ready && n < 100) begin step(); n++; end
    chk({tag, " cmd_ready"}, cmd_ready, 1);
    step();
    cmd_valid = 1'b0;
    exp_q.push_back({exp_err, exp_rdata});
  endtask

  task automatic wait_req(input string tag);
    int n = 0;
    while (!m_req && n < 50) begin step(); n++; end
    chk({tag, " m_req"}, m_req, 1);
  endtask

  task automatic ack(input logic [7:0] d);
    m_ack = 1'b1; m_rdata = d;
    step();
    m_ack = 1'b0; m_rdata = 8'h00;
  endtask

  task automatic take_rsp(input string tag);
    int n = 0;
    logic [8:0] e;
    while (!rsp_valid && n < 100) begin step(); n++; end
    chk({tag, " rsp_valid"}, rsp_valid, 1);
    chk({tag, " scoreboard nonempty"}, exp_q.size() != 0, 1);
    e = (exp_q.size() != 0) ? exp_q.pop_front() : 9'h0;
    chk({tag, " rsp_rdata"}, rsp_rdata, e[7:0]);
    chk({tag, " rsp_err"}, rsp_err, e[8]);
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    chk({tag, " rsp_valid drop"}, rsp_valid, 0);
  endtask

  initial begin
    int n;
    logic seen;
    reset = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = 8'h00; cmd_wdata = 8'h00;
    m_gnt = 1'b0; m_ack = 1'b0; m_rdata = 8'h00; rsp_ready = 1'b0;
    step(); step();
    chk("rst m_req", m_req, 0);
    chk("rst m_write", m_write, 0);
    chk("rst m_addr", m_addr, 0);
    chk("rst m_wdata", m_wdata, 0);
    chk("rst rsp_valid", rsp_valid, 0);
    chk("rst rsp_rdata", rsp_rdata, 0);
    chk("rst rsp_err", rsp_err, 0);
    chk("rst fifo_count", fifo_count, 0);
    chk("rst cmd_ready", cmd_ready, 1);
    reset = 1'b1;
    step();

    // Abort an in-flight command with two more queued.
    push_cmd("t1a", 1'b0, 8'h01, 8'h00, 1'b0, 8'h00);
    push_cmd("t1b", 1'b0, 8'h02, 8'h00, 1'b0, 8'h00);
    push_cmd("t1c", 1'b0, 8'h03, 8'h00, 1'b0, 8'h00);
    chk("t1 fifo_count", fifo_count, 2);
    m_gnt = 1'b1; step(); m_gnt = 1'b0;
    chk("t1 m_req before reset", m_req, 1);
    reset = 1'b0;
    #1;
    chk("t1 m_req", m_req, 0);
    chk("t1 rsp_valid", rsp_valid, 0);
    chk("t1 fifo_count", fifo_count, 0);
    chk("t1 cmd_ready", cmd_ready, 1);
    exp_q.delete();
    step();
    reset = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin step(); seen = seen | rsp_valid | m_req; end
    chk("t1 no response after abort", seen, 0);

    // Read with separate gnt and ack.
    push_cmd("t2", 1'b0, 8'h3C, 8'h00, 1'b0, 8'hA5);
    chk("t2 m_req one cycle", m_req, 0);
    step();
    chk("t2 m_req two cycles", m_req, 1);
    chk("t2 m_addr", m_addr, 8'h3C);
    chk("t2 m_write", m_write, 0);
    step();
    m_gnt = 1'b1; step(); m_gnt = 1'b0;
    chk("t2 m_req wait_ack", m_req, 1);
    step();
    ack(8'hA5);
    chk("t2 m_req after ack", m_req, 0);
    repeat (3) step();
    chk("t2 rsp_valid held", rsp_valid, 1);
    chk("t2 rsp_rdata held", rsp_rdata, 8'hA5);
    take_rsp("t2");

    // Write with gnt and ack together; rdata must be zeroed.
    push_cmd("t3", 1'b1, 8'h10, 8'h77, 1'b0, 8'h00);
    step();
    chk("t3 m_req", m_req, 1);
    chk("t3 m_write", m_write, 1);
    chk("t3 m_addr", m_addr, 8'h10);
    chk("t3 m_wdata", m_wdata, 8'h77);
    m_gnt = 1'b1;
    ack(8'hEE);
    m_gnt = 1'b0;
    chk("t3 m_req after ack", m_req, 0);
    take_rsp("t3");

    // Timeout, then the queued command issues.
    push_cmd("t4a", 1'b0, 8'h20, 8'h00, 1'b1, 8'h00);
    push_cmd("t4b", 1'b0, 8'h21, 8'h00, 1'b0, 8'h5A);
    n = 0;
    while (m_req && n < 40) begin n++; step(); end
    chk("t4 m_req high cycles", n, 16);
    take_rsp("t4a");
    step();
    chk("t4b m_req", m_req, 1);
    chk("t4b m_addr", m_addr, 8'h21);
    ack(8'h5A);
    take_rsp("t4b");

    // Ack on the final timer cycle completes normally.
    push_cmd("t6", 1'b0, 8'h33, 8'h00, 1'b0, 8'hC3);
    repeat (16) step();
    chk("t6 m_req last cycle", m_req, 1);
    ack(8'hC3);
    chk("t6 m_req after ack", m_req, 0);
    take_rsp("t6");

    // Fill the FIFO behind an in-flight command.
    for (int i = 0; i < 5; i++) begin
      logic w;
      logic [7:0] rd;
      w = (i == 2);
      rd = w ? 8'h00 : 8'h90 + 8'(i);
      push_cmd("t5 push", w, 8'h40 + 8'(i), 8'h60 + 8'(i), 1'b0, rd);
    end
    chk("t5 fifo_count full", fifo_count, 4);
    chk("t5 cmd_ready full", cmd_ready, 0);
    chk("t5 m_addr first", m_addr, 8'h40);
    ack(8'h90);
    repeat (2) step();
    chk("t5 cmd_ready in resp", cmd_ready, 0);
    take_rsp("t5 rsp0");
    chk("t5 cmd_ready pop cycle", cmd_ready, 0);
    step();
    chk("t5 cmd_ready after pop", cmd_ready, 1);
    chk("t5 fifo_count after pop", fifo_count, 3);
    for (int i = 1; i < 5; i++) begin
      wait_req("t5 issue");
      chk("t5 m_addr order", m_addr, 8'h40 + 8'(i));
      ack(8'h90 + 8'(i));
      take_rsp("t5 rsp");
    end
    chk("scoreboard drained", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
